key_event: RTL and testbench
============================

# key_event

Converts the debounced, active-high key level from the input debounce stage into single-cycle key events: press, release, long-press and auto-repeat. Sits directly downstream of the debouncer and feeds the control FSMs and counters that need one pulse per user action rather than a level. Fully synchronous to `clock`; all outputs are registered.

## Interface
- `LONG_CYC`, default 50_000_000: cycles the key must stay held after `press` before `long_press` fires; legal range 2 .. 2^CNT_W-1.
- `REP_CYC`, default 10_000_000: auto-repeat period in cycles after `long_press`; legal range 2 .. 2^CNT_W-1.
- `CNT_W`, default 26: width of the internal hold/repeat counter.

- `clock`  in  1  single system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_in`  in  1  debounced key level, synchronous to `clock`, 1 = pressed.
- `enable`  in  1  event generation enable; 0 suppresses all events.
- `press`  out  1  one-cycle pulse on a key press.
- `release`  out  1  one-cycle pulse on a key release that follows a `press`.
- `long_press`  out  1  one-cycle pulse when the hold reaches `LONG_CYC`.
- `repeat`  out  1  one-cycle pulse every `REP_CYC` cycles while held past long-press.
- `held`  out  1  level, 1 while the FSM is in HELD or LONG.

## Operation
- `key_q` registers `key_in` every cycle, independent of `enable`; rise = `key_in & ~key_q`.
- FSM states: IDLE, HELD, LONG. Counter `cnt` is CNT_W bits, unsigned.
- IDLE: on rise with `enable`=1 → HELD, `press`=1, `cnt`=0. Key already high when entering IDLE (or when `enable` rises) produces no press; a fresh rise is required.
- HELD: `key_in`=0 → IDLE, `release`=1, `cnt`=0. Else if `cnt`==LONG_CYC-1 → LONG, `long_press`=1, `cnt`=0. Else `cnt`+1.
- LONG: `key_in`=0 → IDLE, `release`=1, `cnt`=0. Else if `cnt`==REP_CYC-1 → `repeat`=1, `cnt`=0. Else `cnt`+1.
- Release has priority over long_press/repeat when both would occur on the same edge; at most one event pulse is high in any cycle.
- `enable`=0 in any state: next state IDLE, `cnt`=0, all pulses 0, no `release` emitted.
- Counter never wraps: it is cleared at each terminal count and on every state change.
- Reset (`reset_n`=0, any time, including mid-hold): state IDLE, `cnt`=0, `key_q`=0, `press`=`release`=`long_press`=`repeat`=`held`=0. After reset release a key already high at the first edge counts as a rise (since `key_q`=0) and produces `press`.

## Timing
- `press`: high in the cycle after the first rising edge at which `key_in`=1 (latency 1).
- `long_press`: exactly LONG_CYC cycles after `press`.
- First `repeat`: REP_CYC cycles after `long_press`; subsequent ones every REP_CYC cycles.
- `release`: high in the cycle after the first edge sampling `key_in`=0 in HELD/LONG (latency 1).
- `held` rises together with `press` and falls together with `release`.
- All pulses are exactly one cycle wide.

## Configuration
- `KEY_EVENT_REPEAT_EN` defined: LONG state generates `repeat` pulses as above.
- Not defined: `repeat` tied to 0, LONG holds with `cnt` frozen at 0 until release; `long_press`, `press`, `release` unchanged.

## Test plan
- LONG_CYC=8, REP_CYC=4, enable=1: key_in high 3 cycles → `press` at cycle 1, `release` at cycle 4, no `long_press`.
- Same params, key held 20 cycles → `press` t=1, `long_press` t=9, `repeat` t=13, 17, `release` one cycle after key falls; `held` high t=1 through the cycle before `release`.
- Key falls on the edge where `cnt`==7 in HELD → `release` only, no `long_press`.
- Key high, `enable` 0→1 mid-hold → no `press`; after key low then high → `press`. `enable` forced 0 in LONG → IDLE, no `release`.
- `reset_n` asserted in LONG → all outputs 0 immediately; deassert with key_in=1 → `press` one cycle later.
- Build without `KEY_EVENT_REPEAT_EN`, key held 30 cycles → `long_press` at t=9, `repeat` never asserts.

Source files
------------

// File: rtl/key_event.sv
// key_event: debounced key level to press/release/long/repeat pulses.
// Define KEY_EVENT_REPEAT_EN to enable auto-repeat pulses in LONG.
module key_event #(
  parameter int LONG_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000,
  parameter int CNT_W    = 26
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_in,
  input  logic enable,
  output logic press,
  output logic release_ev,
  output logic long_press,
  output logic repeat_ev,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC =
    CNT_W'(LONG_CYC - 1);

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TC =
    CNT_W'(REP_CYC - 1);
`endif

  localparam longint CNT_MAX =
    (longint'(1) << CNT_W) - 1;

  localparam bit CFG_OK =
    (LONG_CYC >= 2) &&
    (REP_CYC >= 2) &&
    (longint'(LONG_CYC) <= CNT_MAX) &&
    (longint'(REP_CYC) <= CNT_MAX);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             key_q;
  logic             key_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;
  logic             long_q;
  logic             long_d;
  logic             repeat_q;
  logic             repeat_d;
  logic             held_q;
  logic             held_d;
  logic             rise;

  assign rise = key_in & ~key_q;

  // key history tracks the input regardless of enable
  always_comb begin
    key_d = key_in;
  end

  // next state, counter and one-hot event pulses
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HELD;
            press_d = 1'b1;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (!key_in) begin
            state_d   = IDLE;
            release_d = 1'b1;
            cnt_d     = '0;
          end else if (cnt_q == LONG_TC) begin
            state_d = LONG;
            long_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG: begin
          if (!key_in) begin
            state_d   = IDLE;
            release_d = 1'b1;
            cnt_d     = '0;
`ifdef KEY_EVENT_REPEAT_EN
          end else if (cnt_q == REP_TC) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          end else begin
            cnt_d = '0;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    held_d = (state_d != IDLE);
  end

  // state, counter and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press      = press_q;
  assign release_ev = release_q;
  assign long_press = long_q;
  assign repeat_ev  = repeat_q;
  assign held       = held_q;

  // parameter legality and event exclusivity
  a_cfg: assert property (
    @(posedge clock) CFG_OK
  );

  a_onehot: assert property (
    @(posedge clock) disable iff (!reset_n)
    $onehot0({press_q, release_q, long_q, repeat_q})
  );

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed checks of key_event pulses.
// Repeat expectations follow KEY_EVENT_REPEAT_EN.
module tb_key_event;

  localparam int LC = 8;
  localparam int RC = 4;
  localparam int W  = 8;

`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic key_in  = 1'b0;
  logic enable  = 1'b0;
  logic press;
  logic release_ev;
  logic long_press;
  logic repeat_ev;
  logic held;

  int n_run  = 0;
  int n_fail = 0;

  key_event #(
    .LONG_CYC(LC),
    .REP_CYC (RC),
    .CNT_W   (W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_in    (key_in),
    .enable    (enable),
    .press     (press),
    .release_ev(release_ev),
    .long_press(long_press),
    .repeat_ev (repeat_ev),
    .held      (held)
  );

  always #5 clock = ~clock;

  // {press, release, long, repeat, held}
  function automatic logic [4:0] outs();
    return {press, release_ev, long_press,
            repeat_ev, held};
  endfunction

  task automatic chk(input string tag,
                     input logic [4:0] got,
                     input logic [4:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b",
               tag, got, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic [4:0] exp);
    @(posedge clock);
    @(negedge clock);
    chk(tag, outs(), exp);
  endtask

  // key high for hi_n edges, then low; t counts cycles
  task automatic scen(input string tag,
                      input int hi_n, input int n,
                      input int t_pr, input int t_rl,
                      input int t_lp, input int t_r0);
    logic [4:0] e;
    key_in = 1'b1;
    for (int t = 1; t <= n; t++) begin
      e    = '0;
      e[4] = (t == t_pr);
      e[3] = (t == t_rl);
      e[2] = (t == t_lp);
      e[1] = REP_ON && (t_r0 > 0) &&
             (t >= t_r0) && (t < t_rl) &&
             ((t - t_r0) % RC == 0);
      e[0] = (t >= t_pr) && (t < t_rl);
      step($sformatf("%s t=%0d", tag, t), e);
      if (t == hi_n) key_in = 1'b0;
    end
  endtask

  // press then hold into LONG (long_press at cycle 9)
  task automatic to_long(input string tag);
    key_in = 1'b1;
    step({tag, " press"}, 5'b10001);
    for (int t = 2; t <= 8; t++)
      step($sformatf("%s h%0d", tag, t), 5'b00001);
    step({tag, " long"}, 5'b00101);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk("reset", outs(), 5'b00000);
    reset_n = 1'b1;
    enable  = 1'b1;
    step("idle", 5'b00000);

    scen("short", 3, 6, 1, 4, 0, 0);
    scen("hold20", 20, 23, 1, 21, 9, 13);
    scen("edge7", 8, 11, 1, 9, 0, 0);
    scen("hold30", 30, 33, 1, 31, 9, 13);

    enable = 1'b0;
    key_in = 1'b1;
    step("en0 a", 5'b00000);
    step("en0 b", 5'b00000);
    enable = 1'b1;
    step("en1 a", 5'b00000);
    step("en1 b", 5'b00000);
    step("en1 c", 5'b00000);
    key_in = 1'b0;
    step("en1 low", 5'b00000);

    to_long("enlong");
    enable = 1'b0;
    step("dis a", 5'b00000);
    step("dis b", 5'b00000);
    enable = 1'b1;
    step("dis re", 5'b00000);
    key_in = 1'b0;
    step("dis low", 5'b00000);

    to_long("rst");
    reset_n = 1'b0;
    #1;
    chk("rst async", outs(), 5'b00000);
    @(negedge clock);
    chk("rst hold", outs(), 5'b00000);
    reset_n = 1'b1;
    step("rst press", 5'b10001);
    key_in = 1'b0;
    step("rst rel", 5'b01000);
    step("rst idle", 5'b00000);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
